// File: rtl/draw_player_anim.sv
// draw_player_anim: player-sprite overlay for the VGA pixel pipeline.
// Draws one player at a latched x position. The pose comes from the movement state,
// legs alternate per frame for the walk animation, and a three-state FSM drives a
// vertical jump. Position, pose, jump and animation only change on the frame tick,
// which is the pixel at vcount==0 && hcount==0.
//
// Ports
//   clk, rst                    pixel clock, asynchronous active-high reset
//   vcount_i .. rgb_i           incoming VGA timing fields and background colour
//   vcount_o .. rgb_o           the same fields delayed exactly 2 clocks, sprite overlaid on rgb
//   xpos_i                      requested sprite left edge (clamped so the sprite stays on screen)
//   state_i                     movement state: 0 IDLE, 1 LEFT1, 2 LEFT2, 3 RIGHT1, 4 RIGHT2
//   jump_req_i                  level request to start a jump (only honoured on the ground)
//   on_ground_o                 1 while the jump FSM is in GROUND
//   jump_state_o                jump FSM state (0 GROUND, 1 RISE, 2 FALL), for observation
//   yoff_o, anim_phase_o        current jump offset and walk phase, for observation
//
// Handshake: none. The block is a fixed 2-stage pipeline that accepts a pixel every
// clock; there is no valid/ready, every input cycle produces an output 2 cycles later.
module draw_player_anim #(
  parameter int          SPRITE_W    = 40,
  parameter int          SPRITE_H    = 90,
  parameter int          GROUND_Y    = 500,
  parameter logic [11:0] BODY_RGB    = 12'hF00,
  parameter logic [11:0] EYE_RGB     = 12'h0FF,
  parameter int          ANIM_DIV    = 8,
  parameter int          JUMP_HEIGHT = 64,
  parameter int          JUMP_STEP   = 4,
  parameter int          HOR_PIXELS  = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [10:0] vcount_i,
  input  logic [10:0] hcount_i,
  input  logic        vsync_i,
  input  logic        hsync_i,
  input  logic        vblnk_i,
  input  logic        hblnk_i,
  input  logic [11:0] rgb_i,
  output logic [10:0] vcount_o,
  output logic [10:0] hcount_o,
  output logic        vsync_o,
  output logic        hsync_o,
  output logic        vblnk_o,
  output logic        hblnk_o,
  output logic [11:0] rgb_o,
  input  logic [11:0] xpos_i,
  input  logic [2:0]  state_i,
  input  logic        jump_req_i,
  output logic        on_ground_o,
  output logic [1:0]  jump_state_o,
  output logic [11:0] yoff_o,
  output logic        anim_phase_o
);

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_LEFT2  = 3'd2;
  localparam logic [2:0] ST_RIGHT2 = 3'd4;

  localparam logic [11:0] X_MAX = 12'(HOR_PIXELS - SPRITE_W);
  localparam logic [11:0] Y_TOP = 12'(GROUND_Y - SPRITE_H);
  localparam logic [11:0] W     = 12'(SPRITE_W);
  localparam logic [11:0] H     = 12'(SPRITE_H);
  localparam logic [11:0] STEP  = 12'(JUMP_STEP);
  localparam logic [11:0] PEAK  = 12'(JUMP_HEIGHT);

  // Front-pose geometry, scaled from the 40x90 reference drawing.
  localparam logic [11:0] EAR_O     = 12'(SPRITE_W / 4);
  localparam logic [11:0] EAR_I     = 12'(SPRITE_W * 3 / 8);
  localparam logic [11:0] EAR_SPLIT = 12'(SPRITE_H / 18);
  localparam logic [11:0] BODY_TOP  = 12'(SPRITE_H / 9);
  localparam logic [11:0] LEG_TOP   = 12'(SPRITE_H * 7 / 9);
  localparam logic [11:0] EYE_SZ    = 12'(SPRITE_W * 6 / 40);
  localparam logic [11:0] EYE_Y     = 12'(SPRITE_H * 27 / 90);
  localparam logic [11:0] EYE_LX    = 12'(SPRITE_W * 7 / 40);
  localparam logic [11:0] EYE_RX    = 12'(SPRITE_W * 24 / 40);
  localparam logic [11:0] LEG_SH    = 12'(SPRITE_W * 3 / 40);
  // Side-pose geometry: the side view is narrower than the box (W - EAR_O wide).
  localparam logic [11:0] SIDE_W    = W - EAR_O;
  localparam logic [11:0] SIDE_EW   = 12'(SPRITE_W / 8);
  localparam logic [11:0] SIDE_EY   = 12'(SPRITE_H * 2 / 9);
  localparam logic [11:0] SIDE_EH   = 12'(SPRITE_H * 2 / 9);

  localparam int            CNT_W    = (ANIM_DIV > 1) ? $clog2(ANIM_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ANIM_DIV - 1);

  typedef enum logic [1:0] {
    JS_GROUND = 2'd0,
    JS_RISE   = 2'd1,
    JS_FALL   = 2'd2
  } jump_state_e;

  // Frame-rate state
  jump_state_e      jst_q, jst_d;
  logic [11:0]      yoff_q, yoff_d;
  logic [11:0]      xpos_q, xpos_d;
  logic [2:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             phase_q, phase_d;
  logic             on_ground_q, on_ground_d;

  logic        frame_tick;
  logic [11:0] yoff_up, yoff_dn;
  logic        walking;

  assign frame_tick = (vcount_i == 11'd0) && (hcount_i == 11'd0);
  assign yoff_up    = yoff_q + STEP;
  assign yoff_dn    = yoff_q - STEP;
  assign walking    = (state_q != ST_IDLE) && (state_q <= ST_RIGHT2);

  always_comb begin
    jst_d   = jst_q;
    yoff_d  = yoff_q;
    xpos_d  = xpos_q;
    state_d = state_q;
    cnt_d   = cnt_q;
    phase_d = phase_q;
    if (frame_tick) begin
      xpos_d  = (xpos_i > X_MAX) ? X_MAX : xpos_i;
      state_d = state_i;
      case (jst_q)
        JS_GROUND: begin
          if (jump_req_i) begin
            jst_d  = JS_RISE;
            yoff_d = STEP;
          end
        end
        JS_RISE: begin
          yoff_d = yoff_up;
          if (yoff_up == PEAK) jst_d = JS_FALL;
        end
        JS_FALL: begin
          yoff_d = yoff_dn;
          if (yoff_dn == 12'd0) jst_d = JS_GROUND;
        end
        default: begin
          jst_d  = JS_GROUND;
          yoff_d = 12'd0;
        end
      endcase
      // Walk animation is judged on the pose and ground status in force this frame.
      if (state_q == ST_IDLE) begin
        cnt_d   = '0;
        phase_d = 1'b0;
      end else if (walking && (jst_q == JS_GROUND)) begin
        if (cnt_q == CNT_LAST) begin
          cnt_d   = '0;
          phase_d = ~phase_q;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
    end
    on_ground_d = (jst_d == JS_GROUND);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      jst_q       <= JS_GROUND;
      yoff_q      <= 12'd0;
      xpos_q      <= 12'd0;
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      phase_q     <= 1'b0;
      on_ground_q <= 1'b1;
    end else begin
      jst_q       <= jst_d;
      yoff_q      <= yoff_d;
      xpos_q      <= xpos_d;
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      phase_q     <= phase_d;
      on_ground_q <= on_ground_d;
    end
  end

  assign on_ground_o  = on_ground_q;
  assign jump_state_o = jst_q;
  assign yoff_o       = yoff_q;
  assign anim_phase_o = phase_q;

  // Stage 1: sprite-relative coordinates. Negative offsets wrap to large values,
  // so a single unsigned compare per axis decides whether we are in the box.
  logic [11:0] dx_c, dy_c;
  assign dx_c = {1'b0, hcount_i} - xpos_q;
  assign dy_c = {1'b0, vcount_i} - (Y_TOP - yoff_q);

  logic [10:0] vcount_s1_q, hcount_s1_q;
  logic        vsync_s1_q, hsync_s1_q, vblnk_s1_q, hblnk_s1_q;
  logic [11:0] rgb_s1_q, dx_s1_q, dy_s1_q;
  logic        inside_s1_q, phase_s1_q;
  logic [2:0]  pose_s1_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vcount_s1_q <= '0;
      hcount_s1_q <= '0;
      vsync_s1_q  <= 1'b0;
      hsync_s1_q  <= 1'b0;
      vblnk_s1_q  <= 1'b0;
      hblnk_s1_q  <= 1'b0;
      rgb_s1_q    <= '0;
      dx_s1_q     <= '0;
      dy_s1_q     <= '0;
      inside_s1_q <= 1'b0;
      pose_s1_q   <= ST_IDLE;
      phase_s1_q  <= 1'b0;
    end else begin
      vcount_s1_q <= vcount_i;
      hcount_s1_q <= hcount_i;
      vsync_s1_q  <= vsync_i;
      hsync_s1_q  <= hsync_i;
      vblnk_s1_q  <= vblnk_i;
      hblnk_s1_q  <= hblnk_i;
      rgb_s1_q    <= rgb_i;
      dx_s1_q     <= dx_c;
      dy_s1_q     <= dy_c;
      inside_s1_q <= (dx_c < W) && (dy_c < H);
      pose_s1_q   <= state_q;
      phase_s1_q  <= phase_q;
    end
  end

  // Stage 2: shape lookup and colour select.
  logic        body, eye;
  logic [11:0] rgb_d;
  logic        side_eye_row;

  assign side_eye_row = (dy_s1_q >= SIDE_EY) && (dy_s1_q < SIDE_EY + SIDE_EH);

  always_comb begin
    body = 1'b0;
    eye  = 1'b0;
    case (pose_s1_q)
      ST_RIGHT2: begin
        body = dx_s1_q < (SIDE_W - SIDE_EW);
        eye  = (dx_s1_q >= SIDE_W - SIDE_EW) && (dx_s1_q < SIDE_W) && side_eye_row;
      end
      ST_LEFT2: begin
        body = (dx_s1_q >= SIDE_EW) && (dx_s1_q < SIDE_W);
        eye  = (dx_s1_q < SIDE_EW) && side_eye_row;
      end
      default: begin
        if (dy_s1_q < EAR_SPLIT) begin
          body = (dx_s1_q < EAR_O) || (dx_s1_q >= W - EAR_O);
        end else if (dy_s1_q < BODY_TOP) begin
          body = (dx_s1_q < EAR_I) || (dx_s1_q >= W - EAR_I);
        end else if (dy_s1_q < LEG_TOP) begin
          body = 1'b1;
          eye  = (dy_s1_q >= EYE_Y) && (dy_s1_q < EYE_Y + EYE_SZ) &&
                 (((dx_s1_q >= EYE_LX) && (dx_s1_q < EYE_LX + EYE_SZ)) ||
                  ((dx_s1_q >= EYE_RX) && (dx_s1_q < EYE_RX + EYE_SZ)));
        end else if (phase_s1_q) begin
          // Second walk phase: both legs step LEG_SH pixels toward the centre.
          body = ((dx_s1_q >= LEG_SH) && (dx_s1_q < EAR_I + LEG_SH)) ||
                 ((dx_s1_q >= W - EAR_I - LEG_SH) && (dx_s1_q < W - LEG_SH));
        end else begin
          body = (dx_s1_q < EAR_I) || (dx_s1_q >= W - EAR_I);
        end
      end
    endcase

    rgb_d = rgb_s1_q;
    if (!(hblnk_s1_q || vblnk_s1_q) && inside_s1_q) begin
      if (eye)       rgb_d = EYE_RGB;
      else if (body) rgb_d = BODY_RGB;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vcount_o <= '0;
      hcount_o <= '0;
      vsync_o  <= 1'b0;
      hsync_o  <= 1'b0;
      vblnk_o  <= 1'b0;
      hblnk_o  <= 1'b0;
      rgb_o    <= '0;
    end else begin
      vcount_o <= vcount_s1_q;
      hcount_o <= hcount_s1_q;
      vsync_o  <= vsync_s1_q;
      hsync_o  <= hsync_s1_q;
      vblnk_o  <= vblnk_s1_q;
      hblnk_o  <= hblnk_s1_q;
      rgb_o    <= rgb_d;
    end
  end

endmodule

// File: tb/tb_draw_player_anim.sv
// Testbench for draw_player_anim with default parameters.
// The bench drives a synthetic pixel stream (random coordinates around the sprite,
// with (0,0) used as the frame tick), predicts every output word from a frame-level
// model of the player, and checks the DUT every clock.
module tb_draw_player_anim;

  localparam int P_IDLE = 0, P_LEFT1 = 1, P_LEFT2 = 2, P_RIGHT1 = 3, P_RIGHT2 = 4;
  localparam int EW = 38;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [10:0] vcount_i = 11'd1, hcount_i = 11'd0;
  logic        vsync_i = 1'b0, hsync_i = 1'b0, vblnk_i = 1'b0, hblnk_i = 1'b1;
  logic [11:0] rgb_i = 12'hABC;
  logic [10:0] vcount_o, hcount_o;
  logic        vsync_o, hsync_o, vblnk_o, hblnk_o;
  logic [11:0] rgb_o;
  logic [11:0] xpos_i = 12'd0;
  logic [2:0]  state_i = 3'd0;
  logic        jump_req_i = 1'b0;
  logic        on_ground_o;
  logic [1:0]  jump_state_o;
  logic [11:0] yoff_o;
  logic        anim_phase_o;

  draw_player_anim dut (
    .clk(clk), .rst(rst),
    .vcount_i(vcount_i), .hcount_i(hcount_i), .vsync_i(vsync_i), .hsync_i(hsync_i),
    .vblnk_i(vblnk_i), .hblnk_i(hblnk_i), .rgb_i(rgb_i),
    .vcount_o(vcount_o), .hcount_o(hcount_o), .vsync_o(vsync_o), .hsync_o(hsync_o),
    .vblnk_o(vblnk_o), .hblnk_o(hblnk_o), .rgb_o(rgb_o),
    .xpos_i(xpos_i), .state_i(state_i), .jump_req_i(jump_req_i),
    .on_ground_o(on_ground_o), .jump_state_o(jump_state_o),
    .yoff_o(yoff_o), .anim_phase_o(anim_phase_o)
  );

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_fail   = 0;
  logic [EW-1:0] exp_q[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Jump is tracked as the number of frames since take-off (0 = on the ground):
  // 16 frames up at 4 px each, 16 frames down.
  int m_xq, m_pose, m_j, m_n;

  function automatic int m_yoff();
    return (m_j <= 16) ? 4 * m_j : 4 * (32 - m_j);
  endfunction

  function automatic logic m_phase();
    return ((m_n / 8) % 2) == 1;
  endfunction

  function automatic logic m_on_ground();
    return m_j == 0;
  endfunction

  task automatic model_reset();
    m_xq = 0; m_pose = P_IDLE; m_j = 0; m_n = 0;
  endtask

  task automatic model_tick(input int xp, input int st, input logic jr);
    if (m_pose == P_IDLE) m_n = 0;
    else if (m_j == 0)    m_n = (m_n + 1) % 16;
    if (m_j == 0)         m_j = jr ? 1 : 0;
    else                  m_j = (m_j + 1 == 32) ? 0 : m_j + 1;
    m_xq   = (xp > 984) ? 984 : xp;
    m_pose = st;
  endtask

  function automatic logic [11:0] model_pixel(int h, int v, logic hb, logic vb, logic [11:0] rgb);
    int dx, dy, off;
    bit body, eye;
    if (hb || vb) return rgb;
    dx = h - m_xq;
    dy = v - (410 - m_yoff());
    if (dx < 0 || dx >= 40 || dy < 0 || dy >= 90) return rgb;
    body = 0; eye = 0;
    case (m_pose)
      P_RIGHT2: begin
        eye  = dx >= 25 && dx <= 29 && dy >= 20 && dy <= 39;
        body = dx < 25;
      end
      P_LEFT2: begin
        eye  = dx <= 4 && dy >= 20 && dy <= 39;
        body = dx >= 5 && dx <= 29;
      end
      default: begin
        if (dy < 5)       body = dx < 10 || dx >= 30;
        else if (dy < 10) body = dx < 15 || dx >= 25;
        else if (dy < 70) begin
          body = 1;
          eye  = dy >= 27 && dy <= 32 && ((dx >= 7 && dx <= 12) || (dx >= 24 && dx <= 29));
        end else begin
          off  = m_phase() ? 3 : 0;
          body = (dx >= off && dx < 15 + off) || (dx >= 25 - off && dx < 40 - off);
        end
      end
    endcase
    if (eye)  return 12'h0FF;
    if (body) return 12'hF00;
    return rgb;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic drive(input int h, input int v, input logic hb, input logic vb,
                       input logic hs, input logic vs, input logic [11:0] rgb);
    @(negedge clk);
    hcount_i = 11'(h); vcount_i = 11'(v);
    hblnk_i = hb; vblnk_i = vb; hsync_i = hs; vsync_i = vs; rgb_i = rgb;
    exp_q.push_back({vs, hs, vb, hb, 11'(v), 11'(h), model_pixel(h, v, hb, vb, rgb)});
    if (h == 0 && v == 0) model_tick(int'(xpos_i), int'(state_i), jump_req_i);
  endtask

  task automatic rand_pixels(input int n);
    int h, v;
    for (int i = 0; i < n; i++) begin
      h = m_xq - 6 + int'($urandom_range(0, 52));
      v = 410 - m_yoff() - 6 + int'($urandom_range(0, 102));
      if (h < 0) h = 0;
      if (h == 0 && v == 0) v = 1;
      drive(h, v, $urandom_range(0, 7) == 0, $urandom_range(0, 15) == 0,
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 12'($urandom_range(0, 4095)));
    end
  endtask

  task automatic frame(input int n);
    drive(0, 0, 1'b1, 1'b1, 1'b0, 1'b1, 12'($urandom_range(0, 4095)));
    rand_pixels(n);
  endtask

  // Releases reset on a negedge. The pipeline output one edge later is the reset
  // contents (all zero); the edge after that shows the inputs held during reset.
  task automatic release_reset();
    @(negedge clk);
    rst = 1'b0;
    exp_q.push_back('0);
    exp_q.push_back({vsync_i, hsync_i, vblnk_i, hblnk_i, vcount_i, hcount_i, rgb_i});
  endtask

  task automatic check_outputs_zero(input string name);
    check({name, "_vga"}, {vcount_o, hcount_o, vsync_o, hsync_o, vblnk_o, hblnk_o, rgb_o}, 64'd0);
    check({name, "_on_ground"}, on_ground_o, 1);
  endtask

  task automatic async_reset_midline();
    @(posedge clk);
    #3;
    rst = 1'b1;
    hcount_i = 11'd0; vcount_i = 11'd1; hblnk_i = 1'b1; vblnk_i = 1'b0;
    hsync_i = 1'b0; vsync_i = 1'b0; rgb_i = 12'hABC;
    #1;
    check_outputs_zero("async_rst");
    exp_q.delete();
    model_reset();
    repeat (2) @(negedge clk);
    release_reset();
  endtask

  // ---------------- compare process ----------------
  logic [EW-1:0] exp_w;
  always @(posedge clk) begin
    #1;
    if (!rst) begin
      if (exp_q.size() >= 2) begin
        exp_w = exp_q.pop_front();
        check("vga_out", {vsync_o, hsync_o, vblnk_o, hblnk_o, vcount_o, hcount_o, rgb_o}, exp_w);
      end
      check("on_ground", on_ground_o, m_on_ground());
      check("yoff", yoff_o, m_yoff());
      check("anim_phase", anim_phase_o, m_phase());
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    model_reset();
    repeat (3) @(negedge clk);
    check_outputs_zero("reset");
    release_reset();
    rand_pixels(20);

    // Standing still at x=100: hand-computed pixels pin the model, DUT follows the queue.
    xpos_i = 12'd100; state_i = 3'(P_IDLE);
    frame(10);
    check("lit_body",  model_pixel(100, 440, 0, 0, 12'h123), 12'hF00);
    check("lit_eye",   model_pixel(107, 437, 0, 0, 12'h123), 12'h0FF);
    check("lit_left",  model_pixel(99, 440, 0, 0, 12'h123), 12'h123);
    drive(100, 440, 0, 0, 1, 0, 12'h123);
    drive(107, 437, 0, 0, 0, 1, 12'h123);
    drive(99, 440, 0, 0, 1, 1, 12'h456);
    drive(100, 440, 1, 0, 0, 0, 12'h789);
    rand_pixels(30);

    // Jump: one-frame request, a second request mid-air must be ignored.
    jump_req_i = 1'b1;
    frame(15);
    jump_req_i = 1'b0;
    for (int f = 2; f <= 32; f++) begin
      if (f == 8) jump_req_i = 1'b1;
      frame(15);
      jump_req_i = 1'b0;
      if (f == 16) begin
        check("lit_peak_yoff", yoff_o, 64);
        check("lit_peak_air", on_ground_o, 0);
      end
    end
    check("lit_landed", on_ground_o, 1);
    check("lit_landed_yoff", yoff_o, 0);
    frame(10);

    // Walk right: phase toggles every 8 walking frames, IDLE clears it.
    state_i = 3'(P_RIGHT1);
    for (int f = 1; f <= 20; f++) begin
      frame(12);
      if (f == 8) check("lit_phase0", anim_phase_o, 0);
      if (f == 9) check("lit_phase1", anim_phase_o, 1);
    end
    state_i = 3'(P_IDLE);
    frame(8);
    frame(8);
    check("lit_idle_phase", anim_phase_o, 0);

    // Clamp at the right edge; mid-frame xpos changes are invisible until the tick.
    xpos_i = 12'd1020;
    frame(10);
    check("lit_clamp_in",  model_pixel(984, 440, 0, 0, 12'h321), 12'hF00);
    check("lit_clamp_out", model_pixel(983, 440, 0, 0, 12'h321), 12'h321);
    drive(984, 440, 0, 0, 0, 0, 12'h321);
    xpos_i = 12'd300;
    rand_pixels(30);
    drive(983, 440, 0, 0, 0, 0, 12'h321);
    frame(20);

    // Side poses, including blanking.
    state_i = 3'(P_LEFT2);
    frame(40);
    check("lit_left2_eye",  model_pixel(302, 435, 0, 0, 12'h111), 12'h0FF);
    check("lit_left2_body", model_pixel(305, 435, 0, 0, 12'h111), 12'hF00);
    check("lit_left2_out",  model_pixel(330, 435, 0, 0, 12'h111), 12'h111);
    drive(302, 435, 0, 0, 0, 0, 12'h111);
    drive(305, 435, 0, 0, 0, 0, 12'h111);
    drive(305, 435, 0, 1, 0, 0, 12'h222);
    state_i = 3'(P_RIGHT2);
    frame(40);

    // Mixed random frames with mid-frame input churn and a walking jump.
    for (int f = 0; f < 40; f++) begin
      xpos_i     = 12'($urandom_range(0, 1100));
      state_i    = 3'($urandom_range(0, 4));
      jump_req_i = ($urandom_range(0, 3) == 0);
      frame(10);
      xpos_i     = 12'($urandom_range(0, 1100));
      state_i    = 3'($urandom_range(0, 4));
      jump_req_i = 1'($urandom_range(0, 1));
      rand_pixels(15);
      if (f == 25) begin
        async_reset_midline();
        rand_pixels(5);
      end
    end

    repeat (3) drive(5, 5, 1, 1, 0, 0, 12'h000);
    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
